// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and counter-width helper for the debounce blocks
package debounce_pkg;

    localparam int unsigned DEF_TICK_DIV   = 25000;
    localparam int unsigned DEF_LIMIT      = 10;
    localparam int unsigned DEF_LONG_LIMIT = 1000;
    localparam int unsigned MAX_CHANNELS   = 32;

    // Width of a counter that must be able to hold max_val; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// rtl/debounce_tick_gen.sv - free-running prescaler, o_tick high while the counter sits at TICK_DIV-1
module debounce_tick_gen
    import debounce_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned     W    = cnt_width(TICK_DIV - 1);
    localparam logic [W-1:0]    LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // With TICK_DIV=1 the counter never leaves 0, so the tick is permanently asserted.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - bank of independent switch debouncers sharing one prescaler tick
// Optional long-press detection is compiled in with DEBOUNCE_LONGPRESS_EN.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned LIMIT       = DEF_LIMIT,
    parameter logic        RESET_STATE = 1'b0,
    parameter int unsigned LONG_LIMIT  = DEF_LONG_LIMIT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [CHANNELS-1:0] i_switch,
    output logic [CHANNELS-1:0] o_switch,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_long,
    output logic                o_tick
);

    localparam int unsigned   CW       = cnt_width(LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("debounce_bank: CHANNELS out of range");
    end
    if (TICK_DIV < 1 || LIMIT < 1 || LONG_LIMIT < 1) begin : g_bad_limits
        $error("debounce_bank: TICK_DIV, LIMIT and LONG_LIMIT must be at least 1");
    end

    logic tick;

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    assign o_tick = tick;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]    sync_q;
        logic [1:0]    sync_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          switch_q;
        logic          switch_d;
        logic          rise_q;
        logic          rise_d;
        logic          fall_q;
        logic          fall_d;

        // sync_q[1] is the metastability-safe copy of the pad.
        always_comb begin
            sync_d   = {sync_q[0], i_switch[i]};
            cnt_d    = cnt_q;
            switch_d = switch_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            if (sync_q[1] == switch_q || !i_enable) begin
                cnt_d = '0;
            end else if (tick) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    switch_d = sync_q[1];
                    rise_d   = sync_q[1];
                    fall_d   = !sync_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync_q   <= {2{RESET_STATE}};
                cnt_q    <= '0;
                switch_q <= RESET_STATE;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                sync_q   <= sync_d;
                cnt_q    <= cnt_d;
                switch_q <= switch_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
            end
        end

        assign o_switch[i] = switch_q;
        assign o_rise[i]   = rise_q;
        assign o_fall[i]   = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
        localparam int unsigned   LW    = cnt_width(LONG_LIMIT);
        localparam logic [LW-1:0] LLAST = LW'(LONG_LIMIT - 1);
        localparam logic [LW-1:0] LSAT  = LW'(LONG_LIMIT);

        logic [LW-1:0] lcnt_q;
        logic [LW-1:0] lcnt_d;
        logic          long_q;
        logic          long_d;

        // Parking lcnt at LONG_LIMIT suppresses repeats until the button is released.
        always_comb begin
            lcnt_d = lcnt_q;
            long_d = 1'b0;
            if (!switch_q || !i_enable) begin
                lcnt_d = '0;
            end else if (tick) begin
                if (lcnt_q == LLAST) begin
                    long_d = 1'b1;
                    lcnt_d = LSAT;
                end else if (lcnt_q < LLAST) begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                lcnt_q <= '0;
                long_q <= 1'b0;
            end else begin
                lcnt_q <= lcnt_d;
                long_q <= long_d;
            end
        end

        assign o_long[i] = long_q;
`else
        assign o_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - directed self-checking bench for debounce_bank
module tb_debounce_bank;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LONG_ON = 1;
`else
    localparam int LONG_ON = 0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_enable;
    logic [3:0] i_switch;
    logic [3:0] o_switch;
    logic [3:0] o_rise;
    logic [3:0] o_fall;
    logic [3:0] o_long;
    logic       o_tick;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    debounce_bank #(
        .CHANNELS    (4),
        .TICK_DIV    (4),
        .LIMIT       (3),
        .RESET_STATE (1'b0),
        .LONG_LIMIT  (5)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .i_switch (i_switch),
        .o_switch (o_switch),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_long   (o_long),
        .o_tick   (o_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
    endtask

    task automatic wait_pulse(input bit want_fall, output int n);
        n = 0;
        while (n < 30) begin
            step(1);
            n++;
            if (want_fall ? |o_fall : |o_rise) break;
        end
    endtask

    initial begin
        int n;
        int ticks;
        int long_cnt;
        int long_at;
        int other;

        i_rst_n  = 1'b0;
        i_enable = 1'b1;
        i_switch = 4'b0000;
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst_switch", 32'(o_switch), 32'h0);
        check("rst_pulses", 32'({o_rise, o_fall, o_long}), 32'h0);
        check("rst_tick", 32'(o_tick), 32'h0);

        // Idle: k counts rising edges since reset release.
        i_rst_n = 1'b1;
        check("idle_tick_k0", 32'(o_tick), 32'h0);
        for (int k = 1; k <= 100; k++) begin
            step(1);
            check("idle_switch", 32'(o_switch), 32'h0);
            check("idle_pulses", 32'({o_rise, o_fall, o_long}), 32'h0);
            check("idle_tick", 32'(o_tick), 32'(k % 4 == 3));
        end

        // Channel 0 rises at k=100; commit lands on edge 112.
        i_switch[0] = 1'b1;
        step(11);
        check("ch0_pre_switch", 32'(o_switch), 32'h0);
        check("ch0_pre_rise", 32'(o_rise), 32'h0);
        step(1);
        check("ch0_commit_switch", 32'(o_switch), 32'h1);
        check("ch0_commit_rise", 32'(o_rise), 32'h1);
        check("ch0_commit_fall", 32'(o_fall), 32'h0);
        step(1);
        check("ch0_rise_width", 32'(o_rise), 32'h0);

        // Long press: fifth tick after commit is consumed on edge 132.
        long_cnt = 0;
        long_at  = -1;
        other    = 0;
        for (int k = 114; k <= 152; k++) begin
            step(1);
            if (|o_long) begin
                long_cnt++;
                long_at = k;
            end
            if (|o_rise || |o_fall) other++;
        end
        check("long_count", 32'(long_cnt), 32'(LONG_ON));
        check("long_edge", 32'(long_at), (LONG_ON == 1) ? 32'd132 : 32'hffff_ffff);
        check("long_other_pulses", 32'(other), 32'h0);
        check("long_switch", 32'(o_switch), 32'h1);

        // Channel 1 bounces: 7 high cycles never span three ticks.
        for (int r = 0; r < 4; r++) begin
            i_switch[1] = 1'b1;
            for (int j = 0; j < 7; j++) begin
                step(1);
                check("bounce_switch", 32'(o_switch), 32'h1);
                check("bounce_pulses", 32'({o_rise, o_fall}), 32'h0);
            end
            i_switch[1] = 1'b0;
            step(1);
            check("bounce_switch", 32'(o_switch), 32'h1);
        end
        for (int j = 0; j < 4; j++) begin
            step(1);
            check("bounce_tail", 32'({o_switch, o_rise, o_fall}), 32'h100);
        end

        // Channels 2 and 3 together.
        i_switch[3:2] = 2'b11;
        wait_pulse(1'b0, n);
        check("pair_rise", 32'(o_rise), 32'hc);
        check("pair_rise_switch", 32'(o_switch), 32'hd);
        check("pair_rise_latency", 32'(n >= 11 && n <= 14), 32'h1);
        step(1);
        check("pair_rise_width", 32'(o_rise), 32'h0);
        i_switch[3:2] = 2'b00;
        wait_pulse(1'b1, n);
        check("pair_fall", 32'(o_fall), 32'hc);
        check("pair_fall_rise", 32'(o_rise), 32'h0);
        check("pair_fall_switch", 32'(o_switch), 32'h1);
        check("pair_fall_latency", 32'(n >= 11 && n <= 14), 32'h1);

        // Release channel 0, then exercise enable gating.
        i_switch[0] = 1'b0;
        wait_pulse(1'b1, n);
        check("ch0_fall", 32'(o_fall), 32'h1);
        check("ch0_fall_switch", 32'(o_switch), 32'h0);
        i_enable    = 1'b0;
        i_switch[0] = 1'b1;
        step(3);
        i_switch[0] = 1'b0;
        step(2);
        i_switch[0] = 1'b1;
        other = 0;
        for (int j = 0; j < 30; j++) begin
            step(1);
            if (o_switch != 4'b0000 || |o_rise || |o_fall || |o_long) other++;
        end
        check("disabled_activity", 32'(other), 32'h0);
        i_enable = 1'b1;
        ticks = 0;
        for (int j = 0; j < 30; j++) begin
            if (o_tick) ticks++;
            step(1);
            if (|o_rise) break;
        end
        check("enable_rise", 32'(o_rise), 32'h1);
        check("enable_ticks", 32'(ticks), 32'd3);

        // Reset in the middle of qualifying channel 2.
        i_switch[2] = 1'b1;
        step(6);
        i_rst_n = 1'b0;
        #1;
        check("midrst_switch", 32'(o_switch), 32'h0);
        check("midrst_pulses", 32'({o_rise, o_fall, o_long}), 32'h0);
        check("midrst_tick", 32'(o_tick), 32'h0);
        i_switch = 4'b0000;
        step(2);
        check("midrst_hold", 32'({o_switch, o_tick}), 32'h0);

        // Channel 3 dips one cycle before its committing tick; k restarts at release.
        i_rst_n     = 1'b1;
        i_switch[3] = 1'b1;
        step(2);
        check("first_tick_k2", 32'(o_tick), 32'h0);
        step(1);
        check("first_tick_k3", 32'(o_tick), 32'h1);
        step(5);
        i_switch[3] = 1'b0;
        step(1);
        i_switch[3] = 1'b1;
        step(2);
        other = 0;
        for (int k = 11; k < 20; k++) begin
            if (o_switch != 4'b0000 || |o_rise) other++;
            step(1);
        end
        check("dip_no_commit", 32'(other), 32'h0);
        check("dip_late_rise", 32'(o_rise), 32'h8);
        check("dip_late_switch", 32'(o_switch), 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel switch/button debouncer for the board's front-panel and DIP-switch inputs. It replaces the single-channel fixed-limit debouncer with a bank of CHANNELS independent channels. All channels share one prescaler tick, and each channel has an input synchroniser. Each channel produces a debounced level, one-cycle rise and fall pulses, and an optional long-press pulse. It sits between the raw pad inputs and the I2C control/configuration logic.

## Interface
Parameters:
- CHANNELS, 4: number of independent switch channels, 1..32.
- TICK_DIV, 25000: clock cycles per debounce tick (1 ms at 25 MHz), ≥1.
- LIMIT, 10: consecutive stable ticks required to accept a new level, ≥1.
- RESET_STATE, 1'b0: level assumed on all channels at reset.
- LONG_LIMIT, 1000: ticks a debounced high must persist to flag a long press, ≥1. Used only with DEBOUNCE_LONGPRESS_EN.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset. Asynchronous assert, active-low.
- i_enable  in  1  when 0, all channel counters are held at 0 and outputs freeze. Synchronisers keep running.
- i_switch  in  CHANNELS  raw asynchronous pad levels.
- o_switch  out  CHANNELS  debounced levels.
- o_rise  out  CHANNELS  one-cycle pulse when o_switch[i] goes 0→1.
- o_fall  out  CHANNELS  one-cycle pulse when o_switch[i] goes 1→0.
- o_long  out  CHANNELS  one-cycle long-press pulse. Tied to 0 when the feature is compiled out.
- o_tick  out  1  prescaler tick, for use by neighbouring blocks.

## Operation
- Synchroniser: 2 flops per channel. Both reset to RESET_STATE, so no edge is reported out of reset.
- Prescaler: tick counter runs 0..TICK_DIV-1 and wraps. o_tick is 1 when the counter equals TICK_DIV-1. If TICK_DIV=1, o_tick is constantly 1.
- Per channel, with s = synchronised input and cnt of width $clog2(LIMIT+1):
  - s == o_switch[i]: cnt←0 every cycle, whether or not a tick occurs. Any glitch restarts qualification.
  - s != o_switch[i], tick, i_enable=1, cnt == LIMIT-1: o_switch[i]←s, cnt←0, and the matching o_rise[i] or o_fall[i] is 1 in that same cycle.
  - s != o_switch[i], tick, i_enable=1, otherwise: cnt←cnt+1.
  - No tick: cnt holds.
- Rise and fall pulses are registered and aligned with the o_switch update. A channel never asserts both in the same cycle. Multiple channels may pulse simultaneously.
- Long press (when compiled in):
  - Per-channel counter lcnt counts ticks while o_switch[i]=1 and i_enable=1.
  - On the tick where lcnt reaches LONG_LIMIT-1, o_long[i] pulses once and lcnt saturates. No repeat until release.
  - lcnt clears whenever o_switch[i]=0.
- i_enable low: cnt and lcnt are forced to 0, and no pulses are generated. The prescaler keeps running.

## Timing
- Reset values:
  - o_switch = {CHANNELS{RESET_STATE}}.
  - o_rise, o_fall, o_long = 0.
  - o_tick = 0; the prescaler counter is 0.
  - All channel counters are 0.
- First tick is asserted TICK_DIV-1 cycles after reset release.
- Input-change latency to o_switch, for a stable input:
  - Synchroniser adds 2 cycles.
  - Then the LIMIT-th tick commits the change: between (LIMIT-1)·TICK_DIV+1 and LIMIT·TICK_DIV cycles.
- Pulses are exactly 1 cycle wide.
- Reset asserted mid-qualification: everything returns to reset values immediately, with no pulse.
- Input returning to its old level one cycle before the committing tick: no commit, and cnt restarts from 0.

## Configuration
- DEBOUNCE_LONGPRESS_EN defined: lcnt counters (width $clog2(LONG_LIMIT+1)) are instantiated and o_long behaves as described above.
- Not defined: no lcnt logic exists, o_long is constant 0, and LONG_LIMIT is ignored.

## Structure
- Shared package debounce_pkg holds:
  - Default constants: DEF_TICK_DIV, DEF_LIMIT, DEF_LONG_LIMIT.
  - MAX_CHANNELS = 32.
  - Counter-width helper function.
- Sub-module debounce_tick_gen (TICK_DIV parameter; i_clk, i_rst_n, o_tick) contains the prescaler. It is reused by other timed blocks.
- Channels are built with a generate loop in debounce_bank; no per-channel sub-module.

## Test plan
Bench uses CHANNELS=4, TICK_DIV=4, LIMIT=3, LONG_LIMIT=5, RESET_STATE=0, with the macro defined unless stated.
- Reset, inputs all 0, run 100 cycles → o_switch=4'b0000 throughout; no pulses; o_tick high every 4th cycle.
- i_switch[0] 0→1 held → o_switch[0]=1 with o_rise[0] pulsing 1 cycle, within 2+[9,12] cycles; other channels unchanged.
- i_switch[1] toggled high for 7 cycles, low for 1, repeated → o_switch[1] stays 0; no pulses.
- Channels 2 and 3 driven high in the same cycle → both rise pulses occur in the same cycle; later both released → o_fall pulses on both.
- Channel 0 held high 40 cycles after commit → exactly one o_long[0] pulse, on the 5th tick after commit. Rebuild without the macro → o_long stays 0.
- i_enable=0 while channel 0 toggles and stays high → no change. Set i_enable=1 → commit after 3 ticks. Assert i_rst_n=0 mid-count → all outputs reset immediately.
